// File: rtl/rle_run_emitter_pkg.sv
// Shared widths, run state encoding and helpers for the RLE run emitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rle_run_emitter_pkg;

  localparam int DEF_DW    = 32;  // symbol width, matches the control block compare width
  localparam int DEF_CW    = 8;   // run-length counter width
  localparam int DEF_DEPTH = 2;   // pair FIFO entries

  typedef enum logic {
    RUN_IDLE = 1'b0,  // no run open
    RUN_OPEN = 1'b1   // sym/cnt hold a live run
  } run_state_e;

  // Largest run length representable in a cw-bit counter.
  function automatic int run_max(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/rle_run_emitter_if.sv
// Handshake bundle between the control block / packer and the run emitter.
// Latency: n/a (wires only).
// Backpressure: in_ready toward the control side, out_ready from the packer.
// Ports: word side in_valid/in_ready/data_in/inc/reset/flush/overflow,
//        pair side out_valid/out_ready/out_sym/out_len.
interface rle_run_emitter_if
  import rle_run_emitter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_in;
  logic          inc;
  logic          reset;
  logic          flush;
  logic          overflow;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_sym;
  logic [CW-1:0] out_len;

  // Driver side: control block plus packer (or a bench standing in for them).
  modport master (
    output in_valid, data_in, inc, reset, flush, out_ready,
    input  in_ready, overflow, out_valid, out_sym, out_len
  );

  // The run emitter itself.
  modport slave (
    input  in_valid, data_in, inc, reset, flush, out_ready,
    output in_ready, overflow, out_valid, out_sym, out_len
  );

endinterface

// File: rtl/rle_pair_fifo.sv
// Small synchronous FIFO holding closed (symbol, length) pairs.
// Latency: a push is visible at head_dat/empty one cycle later.
// Backpressure: push is dropped when full, pop ignored when empty; caller must respect full.
// Ports: clock, sysres_n, push/push_dat, pop, head_dat, full, empty.
module rle_pair_fifo
  import rle_run_emitter_pkg::*;
#(
  parameter int W     = DEF_DW + DEF_CW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clock,
  input  logic         sysres_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge sysres_n) begin
    if (!sysres_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rle_run_emitter.sv
// Tracks the open (symbol, length) run from control inc/reset decisions and queues closed runs.
// Latency: a closed run appears on out_valid one cycle after the closing word or flush is accepted.
// Backpressure: in_ready low while the pair FIFO is full or flush is asserted; flush waits for space.
// Ports: clock, sysres_n (async active-low), bus (slave side of rle_run_emitter_if).
module rle_run_emitter
  import rle_run_emitter_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                clock,
  input  logic                sysres_n,
  rle_run_emitter_if.slave    bus
);

  localparam logic [CW-1:0] RUN_MAX = {CW{1'b1}};

  run_state_e       state_q, state_d;
  logic [DW-1:0]    sym_q, sym_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DW+CW-1:0] head;
  logic             word_acc;
  logic             flush_acc;
  logic             at_max;

  assign bus.in_ready = ~fifo_full & ~bus.flush;
  assign word_acc     = bus.in_valid & bus.in_ready;
  assign flush_acc    = bus.flush & ~fifo_full;
  assign at_max       = (state_q == RUN_OPEN) && (cnt_q == RUN_MAX);
  assign bus.overflow = at_max;

  always_ff @(posedge clock or negedge sysres_n) begin
    if (!sysres_n) begin
      state_q <= RUN_IDLE;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (flush_acc) begin
      if (state_q == RUN_OPEN) begin
        push    = 1'b1;
        state_d = RUN_IDLE;
      end
    end else if (word_acc) begin
      if (state_q == RUN_IDLE) begin
        state_d = RUN_OPEN;
        sym_d   = bus.data_in;
        cnt_d   = CW'(1);
      end else if (bus.inc && !bus.reset && !at_max) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Explicit reset, a word with neither flag (unknown control) or an
        // extend request at RUN_MAX all close the run; the counter never wraps.
        push  = 1'b1;
        sym_d = bus.data_in;
        cnt_d = CW'(1);
      end
    end
  end

  rle_pair_fifo #(
    .W     (DW + CW),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clock    (clock),
    .sysres_n (sysres_n),
    .push     (push),
    .push_dat ({sym_q, cnt_q}),
    .pop      (bus.out_ready),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_sym   = head[CW +: DW];
  assign bus.out_len   = head[CW-1:0];

endmodule

// File: tb/tb_rle_run_emitter.sv
// Scoreboard bench for rle_run_emitter: directed scenarios then randomized words/flushes.
// Latency: n/a.
// Backpressure: out_ready driven directed or randomly.
module tb_rle_run_emitter;
  import rle_run_emitter_pkg::*;

  localparam int DW      = 32;
  localparam int CW      = 3;
  localparam int DEPTH   = 2;
  localparam int RUN_MAX = run_max(CW);

  logic clock = 1'b0;
  logic sysres_n = 1'b0;
  always #5 clock = ~clock;

  rle_run_emitter_if #(.DW(DW), .CW(CW)) bus ();

  rle_run_emitter #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .sysres_n (sysres_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] sym;
    int            len;
  } pair_t;

  pair_t exp_q[$];

  // Reference run: whether a run is open, its symbol and its length.
  bit            m_open = 1'b0;
  logic [DW-1:0] m_sym  = '0;
  int            m_len  = 0;
  // Pairs held by the DUT FIFO, advanced on each rising edge.
  int            occ = 0;
  bit            push_pend = 1'b0;
  bit            pop_pend  = 1'b0;
  bit            rdy_random = 1'b0;
  logic [DW-1:0] prev_word = '0;
  bit            have_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit();
    pair_t p;
    p.sym = m_sym;
    p.len = m_len;
    exp_q.push_back(p);
    push_pend = 1'b1;
  endtask

  // A run grows only while the control block says "same word" and the length
  // has room; anything else closes it and starts a new one-word run.
  task automatic model_word(input logic [DW-1:0] d, input bit inc_i, input bit rst_i);
    if (!m_open) begin
      m_open = 1'b1;
      m_sym  = d;
      m_len  = 1;
    end else if (inc_i && !rst_i && m_len < RUN_MAX) begin
      m_len = m_len + 1;
    end else begin
      emit();
      m_sym = d;
      m_len = 1;
    end
  endtask

  always @(posedge clock) begin
    if (sysres_n) occ = occ + int'(push_pend) - int'(pop_pend);
    push_pend = 1'b0;
    pop_pend  = 1'b0;
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rdy_random) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on each handshake, checks hold stability.
  initial begin
    bit            hold_v;
    logic [DW-1:0] hold_sym;
    logic [CW-1:0] hold_len;
    pair_t         e;
    hold_v = 1'b0;
    hold_sym = '0;
    hold_len = '0;
    forever begin
      @(negedge clock);
      if (!sysres_n) begin
        hold_v = 1'b0;
      end else begin
        check("out_valid", 64'(bus.out_valid), 64'(occ > 0));
        if (hold_v && bus.out_valid) begin
          check("hold_sym", 64'(bus.out_sym), 64'(hold_sym));
          check("hold_len", 64'(bus.out_len), 64'(hold_len));
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pair: got sym=%0h len=%0d expected none", bus.out_sym, bus.out_len);
          end else begin
            e = exp_q.pop_front();
            if (bus.out_sym !== e.sym || int'(bus.out_len) != e.len) begin
              errors++;
              $display("FAIL pair: got (%0h,%0d) expected (%0h,%0d)", bus.out_sym, bus.out_len, e.sym, e.len);
            end
          end
          pop_pend = 1'b1;
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_sym = bus.out_sym;
        hold_len = bus.out_len;
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input bit inc_i, input bit rst_i);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.inc      = inc_i;
    bus.reset    = rst_i;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock);
      check("overflow", 64'(bus.overflow), 64'(m_open && m_len == RUN_MAX));
      check("in_ready", 64'(bus.in_ready), 64'(occ < DEPTH));
      if (occ < DEPTH) begin
        model_word(d, inc_i, rst_i);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL word_timeout: got no accept expected accept within 400 cycles");
    end
    bus.in_valid = 1'b0;
    bus.inc      = 1'b0;
    bus.reset    = 1'b0;
  endtask

  // Control-block stand-in: inc on equal word, reset on mismatch or overflow.
  task automatic ctl_word(input logic [DW-1:0] d);
    bit eq;
    eq = have_prev && (d == prev_word);
    send_word(d, eq, !eq || (m_open && m_len == RUN_MAX));
    prev_word = d;
    have_prev = 1'b1;
  endtask

  task automatic send_flush();
    bit done;
    done = 1'b0;
    bus.flush = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clock);
      check("in_ready_flush", 64'(bus.in_ready), 64'(0));
      if (occ < DEPTH) begin
        if (m_open) begin
          emit();
          m_open = 1'b0;
        end
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: got no accept expected accept within 400 cycles");
    end
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && occ == 0) break;
    end
    @(negedge clock);
    check("drain_valid", 64'(bus.out_valid), 64'(0));
    check("drain_left", 64'(exp_q.size()), 64'(0));
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.inc       = 1'b0;
    bus.reset     = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_sym", 64'(bus.out_sym), 64'(0));
    check("rst_out_len", 64'(bus.out_len), 64'(0));
    check("rst_overflow", 64'(bus.overflow), 64'(0));
    sysres_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clock);
    #1;

    // A,A,A,B then flush with the consumer always ready.
    bus.out_ready = 1'b1;
    ctl_word(32'hA); ctl_word(32'hA); ctl_word(32'hA); ctl_word(32'hB);
    send_flush();
    wait_drain();

    // Nine equal words with a 3-bit counter: split at the maximum length.
    have_prev = 1'b0;
    for (int i = 0; i < RUN_MAX; i++) ctl_word(32'hA);
    @(negedge clock);
    check("ovf_at_max", 64'(bus.overflow), 64'(1));
    @(posedge clock);
    #1;
    ctl_word(32'hA); ctl_word(32'hA);
    send_flush();
    wait_drain();

    // Consumer stalled: two pairs fill the FIFO, the fourth run waits.
    bus.out_ready = 1'b0;
    have_prev = 1'b0;
    ctl_word(32'h1); ctl_word(32'h2); ctl_word(32'h3);
    @(negedge clock);
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    check("full_out_sym", 64'(bus.out_sym), 64'(32'h1));
    @(posedge clock);
    #1;
    fork
      begin ctl_word(32'h4); send_flush(); end
      begin repeat (6) @(posedge clock); #1; bus.out_ready = 1'b1; end
    join
    wait_drain();

    // inc and reset together: reset closes the run.
    have_prev = 1'b0;
    send_word(32'h55, 1'b0, 1'b0);
    send_word(32'h55, 1'b1, 1'b0);
    send_word(32'h55, 1'b1, 1'b1);
    send_word(32'h66, 1'b0, 1'b0);
    send_flush();
    wait_drain();

    // Reset mid-run with a queued pair and the open run at the maximum.
    bus.out_ready = 1'b0;
    have_prev = 1'b0;
    ctl_word(32'h7);
    for (int i = 0; i < RUN_MAX; i++) ctl_word(32'h8);
    @(negedge clock);
    check("pre_rst_ovf", 64'(bus.overflow), 64'(1));
    @(posedge clock);
    #1;
    sysres_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_ovf", 64'(bus.overflow), 64'(0));
    exp_q.delete();
    occ = 0;
    m_open = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sysres_n = 1'b1;
    bus.out_ready = 1'b1;
    ctl_word(32'hC); ctl_word(32'hD);
    send_flush();
    wait_drain();

    // Flush with nothing open, then flush against a full FIFO.
    send_flush();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("noop_flush_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    have_prev = 1'b0;
    ctl_word(32'h21); ctl_word(32'h22); ctl_word(32'h23);
    fork
      send_flush();
      begin
        repeat (5) @(posedge clock);
        #1; bus.out_ready = 1'b1;
        @(posedge clock);
        #1; bus.out_ready = 1'b0;
      end
    join
    @(negedge clock);
    check("held_flush_valid", 64'(bus.out_valid), 64'(1));
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Randomized: small alphabet with long runs, occasional raw inc/reset and flushes.
    rdy_random = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 700; i++) begin
      int r;
      logic [DW-1:0] w;
      r = $urandom_range(0, 99);
      if (have_prev && $urandom_range(0, 9) < 7) w = prev_word;
      else w = DW'($urandom_range(0, 2));
      if (r < 5) begin
        send_flush();
      end else if (r < 12) begin
        send_word(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        prev_word = w;
        have_prev = 1'b1;
      end else begin
        ctl_word(w);
      end
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    send_flush();
    rdy_random = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
